// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit-counter width able to hold the values 0..width.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, one fs_cell per bit-cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output o_ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             o_ovf,
`endif
  output logic             o_bout
);

  import serial_sub_pkg::*;

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_next;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_last;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  fs_cell u_cell (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_borrow),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  assign w_last = (r_cnt == LAST);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = SHIFT;
      SHIFT:   if (w_last)  w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // New bit enters at the MSB; after WIDTH shifts the LSB-first stream is in place.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: datapath registers are reset too, since diff/bout must read 0 straight after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_borrow <= i_bin;
            r_cnt    <= '0;
          end
        end
        SHIFT: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_borrow <= w_bout;
          r_res    <= w_res_next;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into the MSB differs from borrow out of it exactly on signed overflow.
            r_ovf  <= r_borrow ^ w_bout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy = (r_state == SHIFT);
  assign o_done = (r_state == DONE);
  assign o_diff = r_diff;
  assign o_bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign o_ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=1 and WIDTH=8 against an arithmetic model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       s1_start = 1'b0, s1_a = 1'b0, s1_b = 1'b0, s1_bin = 1'b0;
  logic       s1_busy, s1_done, s1_bout;
  logic [0:0] s1_diff;
  logic       s1_ovf;

  logic       s8_start = 1'b0, s8_bin = 1'b0;
  logic [7:0] s8_a = '0, s8_b = '0;
  logic       s8_busy, s8_done, s8_bout;
  logic [7:0] s8_diff;
  logic       s8_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] prev_diff = '0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(s1_start), .i_a(s1_a), .i_b(s1_b), .i_bin(s1_bin),
    .o_busy(s1_busy), .o_done(s1_done), .o_diff(s1_diff),
`ifdef SERIAL_SUB_OVF_EN
    .o_ovf(s1_ovf),
`endif
    .o_bout(s1_bout)
  );

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_start(s8_start), .i_a(s8_a), .i_b(s8_b), .i_bin(s8_bin),
    .o_busy(s8_busy), .o_done(s8_done), .o_diff(s8_diff),
`ifdef SERIAL_SUB_OVF_EN
    .o_ovf(s8_ovf),
`endif
    .o_bout(s8_bout)
  );

`ifndef SERIAL_SUB_OVF_EN
  assign s1_ovf = 1'b0;
  assign s8_ovf = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic int ref_sub(input int w, input int a, input int b, input int bin);
    return a - b - bin;
  endfunction

  function automatic logic ref_ovf(input int w, input int a, input int b, input int bin);
    int sa, sb, r, lim;
    lim = 1 << (w - 1);
    sa  = (a >= lim) ? a - (1 << w) : a;
    sb  = (b >= lim) ? b - (1 << w) : b;
    r   = sa - sb - bin;
    return (r < -lim) || (r > lim - 1);
  endfunction

  // Called at a negedge with u_dut8 idle; returns at a negedge with it idle again.
  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int   r, n;
    bit   seen;
    logic [7:0] exp_d;
    r     = ref_sub(8, int'(a), int'(b), int'(bin));
    exp_d = r[7:0];
    s8_start = 1'b1; s8_a = a; s8_b = b; s8_bin = bin;
    @(posedge clk); #1;
    s8_start = 1'b0; s8_a = 8'($urandom); s8_b = 8'($urandom); s8_bin = 1'($urandom);
    check("w8_acc_busy", s8_busy, 1);
    n = 0; seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1; n++;
      if (s8_done) seen = 1;
      else begin
        check("w8_shift_busy", s8_busy, 1);
        check("w8_diff_hold", s8_diff, prev_diff);
      end
    end
    check("w8_done_latency", n, 8);
    check("w8_done_busy_low", s8_busy, 0);
    check("w8_diff", s8_diff, exp_d);
    check("w8_bout", s8_bout, r < 0);
`ifdef SERIAL_SUB_OVF_EN
    check("w8_ovf", s8_ovf, ref_ovf(8, int'(a), int'(b), int'(bin)));
`endif
    prev_diff = exp_d;
    @(posedge clk); #1;
    check("w8_done_pulse", s8_done, 0);
    @(negedge clk);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic bin);
    int r;
    r = ref_sub(1, int'(a), int'(b), int'(bin));
    s1_start = 1'b1; s1_a = a; s1_b = b; s1_bin = bin;
    @(posedge clk); #1;
    s1_start = 1'b0; s1_a = ~a; s1_b = ~b; s1_bin = ~bin;
    check("w1_acc_busy", s1_busy, 1);
    check("w1_acc_done", s1_done, 0);
    @(posedge clk); #1;
    check("w1_done", s1_done, 1);
    check("w1_diff", s1_diff, r & 1);
    check("w1_bout", s1_bout, r < 0);
`ifdef SERIAL_SUB_OVF_EN
    check("w1_ovf", s1_ovf, ref_ovf(1, int'(a), int'(b), int'(bin)));
`endif
    @(posedge clk); #1;
    check("w1_done_pulse", s1_done, 0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] ea, eb;
    logic       ebin;
    int         r;

    #1;
    check("rst_w8_busy", s8_busy, 0);
    check("rst_w8_done", s8_done, 0);
    check("rst_w8_diff", s8_diff, 0);
    check("rst_w8_bout", s8_bout, 0);
    check("rst_w8_ovf", s8_ovf, 0);
    check("rst_w1_state", {s1_busy, s1_done, s1_diff, s1_bout}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // WIDTH=1 full-subtractor truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op1(v[2], v[1], v[0]);
    end

    // WIDTH=8 directed cases.
    run_op8(8'h05, 8'h03, 1'b0);
    run_op8(8'h03, 8'h05, 1'b0);
    run_op8(8'h00, 8'h00, 1'b1);
    run_op8(8'h80, 8'h01, 1'b0);
    run_op8(8'h7F, 8'hFF, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b1);

    // WIDTH=8 random operations.
    for (int i = 0; i < 20; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom));

    // start held high with operands changing every cycle: acceptances every 10 edges.
    ea = '0; eb = '0; ebin = 1'b0;
    s8_start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_bin = 1'($urandom);
      if (k % 10 == 0) begin
        ea = s8_a; eb = s8_b; ebin = s8_bin;
      end
      @(posedge clk); #1;
      check("cont_overlap", s8_busy & s8_done, 0);
      check("cont_done", s8_done, (k % 10) == 8);
      if (k % 10 == 8) begin
        r = ref_sub(8, int'(ea), int'(eb), int'(ebin));
        check("cont_diff", s8_diff, r & 8'hFF);
        check("cont_bout", s8_bout, r < 0);
        prev_diff = 8'(r);
      end
      @(negedge clk);
    end
    s8_start = 1'b0;
    @(negedge clk);

    // Leave a non-zero result, then reset in the middle of an operation.
    run_op8(8'h03, 8'h05, 1'b0);
    s8_start = 1'b1; s8_a = 8'h80; s8_b = 8'h01; s8_bin = 1'b0;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", s8_busy, 0);
    check("mid_rst_done", s8_done, 0);
    check("mid_rst_diff", s8_diff, 0);
    check("mid_rst_bout", s8_bout, 0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) rst_n = 1'b1;
      check("post_rst_no_done", s8_done, 0);
    end
    prev_diff = '0;
    @(negedge clk);
    run_op8(8'h80, 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
